dwt97_transpose: RTL and testbench
==================================

# dwt97_transpose

2x2 tile transpose for the DWT 9/7 datapath. It sits between the horizontal and vertical lifting stages. It accepts a valid/ready stream of two-sample words, treats each consecutive word pair as the two rows of a 2x2 tile, and emits the tile's two columns as two output words. Word count per line and SOF/EOL framing are preserved, so downstream stages see the same line structure with samples regrouped.

## Interface
- DataWidth, default 16: width of one sample; a stream word carries two samples (2*DataWidth bits).
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- s_ready_o  output  1  upstream ready.
- s_valid_i  input  1  upstream valid.
- s_sof_i  input  1  first word of a frame.
- s_eol_i  input  1  last word of a line.
- s_data_i  input  2*DataWidth  {hi sample [2DW-1:DW], lo sample [DW-1:0]}.
- m_ready_i  input  1  downstream ready.
- m_valid_o  output  1  downstream valid.
- m_sof_o  output  1  first output word of a frame.
- m_eol_o  output  1  last output word of a line.
- m_data_o  output  2*DataWidth  transposed word, same hi/lo packing.

## Operation
- A transfer occurs on a clock edge with valid=1 and ready=1, on either port.
- Tiling:
  - Input words are paired in acceptance order: even-phase word A={a_hi,a_lo}, odd-phase word B={b_hi,b_lo}.
  - Output is two words in order: out0={b_lo,a_lo}, then out1={b_hi,a_hi}.
- Line length must be an even word count; the phase toggles on every accepted word.
- Storage:
  - Hold register H (plus valid flag) for word A.
  - Output buffer of two words O0/O1, with count 0..2 and a sideband bit per word.
- Even phase: accepted A is written to H together with its sof flag. s_ready_o = 1 whenever H is empty.
- Odd phase:
  - s_ready_o = (out_count==0) || (out_count==1 && m_ready_i). This is a combinational path from m_ready_i to s_ready_o.
  - On accepting B, O0/O1 load out0/out1 and out_count becomes 2. H is cleared in the same edge.
- Output:
  - m_valid_o = (out_count != 0); m_data_o shows the head of the buffer.
  - Each m_valid_o&&m_ready_i transfer pops one word.
- Sideband:
  - m_sof_o=1 on out0 iff word A carried s_sof_i.
  - m_eol_o=1 on out1 iff word B carried s_eol_i.
  - All other output words carry 0 on both.
- Resync: s_sof_i=1 on an odd-phase word discards H. That word becomes word A of a new tile.
- s_eol_i on an even-phase word is ignored (not propagated); pairing continues.
- Sample values pass through unmodified; there is no arithmetic.

## Timing
- While rst_i=0:
  - m_valid_o=0, m_sof_o=0, m_eol_o=0, m_data_o=0, s_ready_o=0.
  - H, phase and out_count are cleared.
- s_ready_o=1 from the first clock edge after reset release.
- Reset mid-tile discards H and the output buffer. The phase returns to even.
- Latency: out0 is presented (m_valid_o=1) in the cycle after B is accepted; out1 follows in the next cycle if m_ready_i=1.
- Throughput: with s_valid_i=m_ready_i=1 continuously, one word per cycle on both ports after 2 cycles of initial latency; s_ready_o never drops.
- Backpressure: m_data_o, m_sof_o and m_eol_o hold stable while m_valid_o=1 and m_ready_i=0.
- Loss: no word is lost or duplicated under any valid/ready pattern.
- A simultaneous pop of out1 and load of a new tile in the same edge is legal: out_count goes 1->2.

## Test plan
- Line of 8 words {2i+1,2i}, i=0..7, s_sof_i on word 0, s_eol_i on word 7, valid/ready tied 1:
  - output {2,0},{3,1},{6,4},{7,5},{10,8},{11,9},{14,12},{15,13};
  - m_sof_o only on word 0, m_eol_o only on word 7.
- Same line with s_valid_i and m_ready_i each randomized 50% per cycle: identical output sequence, and m_eol_o asserted on every 8th output word.
- Send words {1,0},{3,2} then hold m_ready_i=0 for 10 cycles:
  - m_data_o stays {2,0} with m_valid_o=1;
  - s_ready_o=1 for the next even word, then 0 for the following odd word until the buffer drains.
- Continuous streaming of 4 lines (32 words), both sides always ready: first output 2 cycles after first input, then one output per cycle, and s_ready_o constantly 1.
- Accept {1,0}, then assert rst_i=0 for 2 cycles, then send {3,2},{5,4}: the first output is {4,2}, and all outputs are 0 during reset.
- Send {1,0} (no sof), then {3,2} with s_sof_i=1, then {5,4}: the output is {4,2} with m_sof_o=1, followed by {5,3}.

Source files
------------

// File: rtl/dwt97_transpose.sv
// 2x2 tile transpose between the horizontal and vertical DWT 9/7 lifting stages.
// Word pairs {A,B} are the rows of a tile. They leave as columns {b_lo,a_lo} then {b_hi,a_hi}.
module dwt97_transpose #(
    parameter int DataWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [2*DataWidth-1:0] s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o
);

    localparam int W2 = 2 * DataWidth;

    logic          run_q;
    logic          h_valid_q;
    logic          h_sof_q;
    logic [W2-1:0] h_data_q;
    logic [W2-1:0] o0_q;
    logic [W2-1:0] o1_q;
    logic          o0_sof_q;
    logic          o0_eol_q;
    logic          o1_eol_q;
    logic [1:0]    out_count_q;

    logic s_fire;
    logic m_fire;
    logic tile_load;

    // h_valid_q doubles as the phase bit: set means the next word is the odd (B) row.
    // The odd-phase ready looks through to m_ready_i so a pop and a reload can share one edge.
    assign s_ready_o = run_q && (!h_valid_q || (out_count_q == 2'd0) ||
                                 ((out_count_q == 2'd1) && m_ready_i));
    assign m_valid_o = (out_count_q != 2'd0);
    assign m_data_o  = o0_q;
    assign m_sof_o   = o0_sof_q;
    assign m_eol_o   = o0_eol_q;

    assign s_fire    = s_valid_i && s_ready_o;
    assign m_fire    = m_valid_o && m_ready_i;
    // An odd-phase sof word restarts the tile instead of completing it.
    assign tile_load = s_fire && h_valid_q && !s_sof_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            run_q       <= 1'b0;
            h_valid_q   <= 1'b0;
            h_sof_q     <= 1'b0;
            h_data_q    <= '0;
            o0_q        <= '0;
            o1_q        <= '0;
            o0_sof_q    <= 1'b0;
            o0_eol_q    <= 1'b0;
            o1_eol_q    <= 1'b0;
            out_count_q <= 2'd0;
        end else begin
            run_q <= 1'b1;

            if (s_fire) begin
                if (!h_valid_q || s_sof_i) begin
                    h_valid_q <= 1'b1;
                    h_sof_q   <= s_sof_i;
                    h_data_q  <= s_data_i;
                end else begin
                    h_valid_q <= 1'b0;
                    h_sof_q   <= 1'b0;
                end
            end

            if (tile_load) begin
                o0_q        <= {s_data_i[DataWidth-1:0], h_data_q[DataWidth-1:0]};
                o1_q        <= {s_data_i[W2-1:DataWidth], h_data_q[W2-1:DataWidth]};
                o0_sof_q    <= h_sof_q;
                o0_eol_q    <= 1'b0;
                o1_eol_q    <= s_eol_i;
                out_count_q <= 2'd2;
            end else if (m_fire) begin
                o0_q        <= o1_q;
                o0_sof_q    <= 1'b0;
                o0_eol_q    <= (out_count_q == 2'd2) ? o1_eol_q : 1'b0;
                out_count_q <= out_count_q - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_dwt97_transpose.sv
// Directed bench for dwt97_transpose: framing, tiling, backpressure, reset and resync scenarios.
module tb_dwt97_transpose;

    logic        clk;
    logic        rst_n;
    logic        s_ready;
    logic        s_valid;
    logic        s_sof;
    logic        s_eol;
    logic [31:0] s_data;
    logic        m_ready;
    logic        m_valid;
    logic        m_sof;
    logic        m_eol;
    logic [31:0] m_data;

    int tests = 0;
    int fails = 0;
    int ncyc  = 0;
    bit rnd_ready = 0;

    logic [33:0] out_q[$];
    int          out_cyc[$];
    int          in_cyc[$];

    logic [15:0] line_hi[8] = '{16'd2, 16'd3, 16'd6, 16'd7, 16'd10, 16'd11, 16'd14, 16'd15};
    logic [15:0] line_lo[8] = '{16'd0, 16'd1, 16'd4, 16'd5, 16'd8, 16'd9, 16'd12, 16'd13};

    dwt97_transpose #(.DataWidth(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .s_ready_o (s_ready),
        .s_valid_i (s_valid),
        .s_sof_i   (s_sof),
        .s_eol_i   (s_eol),
        .s_data_i  (s_data),
        .m_ready_i (m_ready),
        .m_valid_o (m_valid),
        .m_sof_o   (m_sof),
        .m_eol_o   (m_eol),
        .m_data_o  (m_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst_n && m_valid && m_ready) begin
                out_q.push_back({m_sof, m_eol, m_data});
                out_cyc.push_back(ncyc);
            end
            if (rst_n && s_valid && s_ready) in_cyc.push_back(ncyc);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic clear_logs();
        out_q.delete();
        out_cyc.delete();
        in_cyc.delete();
    endtask

    task automatic send(input logic [31:0] d, input logic sof, input logic eol, input bit rnd,
                        output int tries);
        bit done = 0;
        tries = 0;
        while (!done && tries < 200) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = d;
            s_sof   = sof;
            s_eol   = eol;
            @(negedge clk);
            done = s_valid && s_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %h not accepted after %0d cycles", d, tries);
        end
    endtask

    task automatic wait_out(input int n, input string name);
        int b = 0;
        while (out_q.size() < n && b < 300) begin
            @(posedge clk);
            b++;
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_q.size() != n) begin
            fails++;
            $display("FAIL %s_count: got %0d output words, expected %0d", name, out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0; m_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({m_valid, m_sof, m_eol, m_data, s_ready} !== 36'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b sof=%b eol=%b data=%h rdy=%b, expected all 0",
                     m_valid, m_sof, m_eol, m_data, s_ready);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got s_ready=%b, expected 1", s_ready);
        end
    endtask

    task automatic test_line(input bit rnd);
        int t;
        clear_logs();
        rnd_ready = rnd;
        m_ready   = 1'b1;
        for (int i = 0; i < 8; i++)
            send({16'(2 * i + 1), 16'(2 * i)}, i == 0, i == 7, rnd, t);
        wait_out(8, rnd ? "line_rnd" : "line");
        rnd_ready = 0;
        m_ready   = 1'b1;
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            tests++;
            if (out_q[i] !== {i == 0, i == 7, line_hi[i], line_lo[i]}) begin
                fails++;
                $display("FAIL line_word%0d (rnd=%0d): got %h, expected %h", i, rnd, out_q[i],
                         {i == 0, i == 7, line_hi[i], line_lo[i]});
            end
        end
    endtask

    task automatic test_backpressure();
        int t;
        clear_logs();
        m_ready = 1'b0;
        send(32'h0001_0000, 1'b0, 1'b0, 0, t);
        send(32'h0003_0002, 1'b0, 1'b0, 0, t);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (m_valid !== 1'b1 || m_data !== 32'h0002_0000) begin
                fails++;
                $display("FAIL bp_hold cyc%0d: got v=%b data=%h, expected v=1 data=00020000",
                         i, m_valid, m_data);
            end
        end
        @(posedge clk);
        #1;
        send(32'h0005_0004, 1'b0, 1'b0, 0, t);
        tests++;
        if (t != 1) begin
            fails++;
            $display("FAIL bp_even_ready: even word took %0d cycles, expected 1", t);
        end
        s_valid = 1'b1;
        s_data  = 32'h0007_0006;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (s_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_odd_stall cyc%0d: got s_ready=%b, expected 0", i, s_ready);
            end
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        send(32'h0007_0006, 1'b0, 1'b0, 0, t);
        wait_out(4, "bp");
        if (out_q.size() == 4) begin
            tests++;
            if (out_q[0] !== 34'h0_0002_0000 || out_q[1] !== 34'h0_0003_0001 ||
                out_q[2] !== 34'h0_0006_0004 || out_q[3] !== 34'h0_0007_0005) begin
                fails++;
                $display("FAIL bp_order: got %h %h %h %h, expected 000020000 000030001 000060004 000070005",
                         out_q[0], out_q[1], out_q[2], out_q[3]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int total = 0;
        logic [33:0] e;
        clear_logs();
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send({16'(2 * i + 1), 16'(2 * i)}, i == 0, (i % 8) == 7, 0, t);
            total += t;
        end
        wait_out(32, "stream");
        tests++;
        if (total != 32) begin
            fails++;
            $display("FAIL stream_ready: 32 words took %0d cycles, expected 32", total);
        end
        if (out_q.size() == 32 && in_cyc.size() == 32) begin
            tests++;
            if (out_cyc[0] - in_cyc[0] != 2) begin
                fails++;
                $display("FAIL stream_latency: got %0d cycles, expected 2", out_cyc[0] - in_cyc[0]);
            end
            tests++;
            if (out_cyc[31] - out_cyc[0] != 31) begin
                fails++;
                $display("FAIL stream_rate: 32 outputs spanned %0d cycles, expected 31",
                         out_cyc[31] - out_cyc[0]);
            end
            for (int k = 0; k < 16; k++) begin
                e = {k == 0, 1'b0, 16'(4 * k + 2), 16'(4 * k)};
                tests++;
                if (out_q[2 * k] !== e) begin
                    fails++;
                    $display("FAIL stream_out%0d: got %h, expected %h", 2 * k, out_q[2 * k], e);
                end
                e = {1'b0, (k % 4) == 3, 16'(4 * k + 3), 16'(4 * k + 1)};
                tests++;
                if (out_q[2 * k + 1] !== e) begin
                    fails++;
                    $display("FAIL stream_out%0d: got %h, expected %h", 2 * k + 1, out_q[2 * k + 1], e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        clear_logs();
        m_ready = 1'b1;
        send(32'h0001_0000, 1'b0, 1'b0, 0, t);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if ({m_valid, m_sof, m_eol, m_data, s_ready} !== 36'd0) begin
                fails++;
                $display("FAIL midrst_outputs cyc%0d: got v=%b sof=%b eol=%b data=%h rdy=%b, expected all 0",
                         i, m_valid, m_sof, m_eol, m_data, s_ready);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h0003_0002, 1'b0, 1'b0, 0, t);
        send(32'h0005_0004, 1'b0, 1'b0, 0, t);
        wait_out(2, "midrst");
        if (out_q.size() == 2) begin
            tests++;
            if (out_q[0] !== 34'h0_0004_0002 || out_q[1] !== 34'h0_0005_0003) begin
                fails++;
                $display("FAIL midrst_data: got %h %h, expected 000040002 000050003", out_q[0], out_q[1]);
            end
        end
    endtask

    task automatic test_resync();
        int t;
        clear_logs();
        m_ready = 1'b1;
        send(32'h0001_0000, 1'b0, 1'b0, 0, t);
        send(32'h0003_0002, 1'b1, 1'b0, 0, t);
        send(32'h0005_0004, 1'b0, 1'b0, 0, t);
        wait_out(2, "resync");
        if (out_q.size() == 2) begin
            tests++;
            if (out_q[0] !== {1'b1, 1'b0, 32'h0004_0002}) begin
                fails++;
                $display("FAIL resync_out0: got %h, expected %h", out_q[0], {1'b1, 1'b0, 32'h0004_0002});
            end
            tests++;
            if (out_q[1] !== 34'h0_0005_0003) begin
                fails++;
                $display("FAIL resync_out1: got %h, expected 000050003", out_q[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line(0);
        test_line(1);
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_resync();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
